keypad_scan_ctrl: RTL and testbench
===================================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SettleCycles, default 4, meaning clock cycles between driving a column and sampling rows (range 2..15).
REQ-002 SHALL have parameter DebounceScans, default 3, meaning consecutive differing scans needed to change a key state (range 1..7).
REQ-003 SHALL have parameter FifoDepth, default 4, meaning event queue depth (power of 2, range 2..8).
REQ-004 SHALL use one clock and a synchronous, active-high reset; the ports are named clock and reset.
REQ-005 SHALL have port clock, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port tick, input, 1 bit: one-cycle scan-start strobe.
REQ-008 SHALL have port row_in, input, 4 bits: asynchronous matrix rows, active-low, pulled up externally.
REQ-009 SHALL have port col_out, output, 4 bits: column drive, active-low, at most one bit low.
REQ-010 SHALL have port key_state, output, 16 bits: debounced state, 1 = pressed, index = col*4+row.
REQ-011 SHALL have port evt_valid, output, 1 bit: event queue non-empty.
REQ-012 SHALL have port evt_ready, input, 1 bit: consumer accepts head event.
REQ-013 SHALL have port evt_code, output, 5 bits: {press, key index[3:0]}; press 1 = press, 0 = release.
REQ-014 SHALL have port overflow, output, 1 bit: one-cycle pulse when an event is dropped.

Function
REQ-015 SHALL pass row_in through a 2-flop synchronizer before use.
REQ-016 FSM SHALL have states IDLE, SETTLE, SAMPLE, UPDATE; in IDLE col_out = 4'hF.
REQ-017 IDLE -> SETTLE on tick, with column index c = 0.
REQ-018 SETTLE SHALL drive col_out bit c low, count SettleCycles cycles, then go to SAMPLE.
REQ-019 SAMPLE SHALL capture the inverted synchronized rows into row_cap (1 = pressed) in one cycle, then go to UPDATE.
REQ-020 UPDATE SHALL process rows r = 0..3, one per cycle; after r = 3 it SHALL go to SETTLE with c+1, or to IDLE if c = 3.
REQ-021 Per-key counter SHALL clear when the sample equals key_state[k] and increment when it differs.
REQ-022 When the counter reaches DebounceScans, key_state[k] SHALL toggle and the counter SHALL clear in the same cycle.
REQ-023 A toggle SHALL push one event into the queue in the same cycle; evt_valid SHALL rise the following cycle.
REQ-024 Events SHALL pop when evt_valid && evt_ready, in FIFO order.
REQ-025 Push to a full queue SHALL drop the event and pulse overflow; key_state SHALL still toggle.
REQ-026 Simultaneous push and pop on a full queue SHALL accept both, with no overflow.
REQ-027 A tick outside IDLE SHALL be ignored.
REQ-028 A full scan SHALL take 4*(SettleCycles+1+4) cycles.

Reset
REQ-029 Reset SHALL force IDLE, c = 0, r = 0, col_out = 4'hF, key_state = 0, all counters = 0, queue empty, evt_valid = 0, evt_code = 0, overflow = 0, synchronizer flops = 1.
REQ-030 Reset asserted mid-scan SHALL abandon the scan, with no event emitted in that cycle.

Configuration
REQ-031 With KEYPAD_SCAN_CTRL_RELEASE_EVT_EN defined, both press and release toggles SHALL push events.
REQ-032 Without KEYPAD_SCAN_CTRL_RELEASE_EVT_EN, only press toggles SHALL push events; release toggles update key_state only and never cause overflow.

Structure
REQ-033 Package keypad_scan_pkg SHALL hold the FSM state enum, the event-code typedef (press bit + 4-bit index), and the ROWS/COLS = 4 constants.
REQ-034 The event queue SHALL be sub-module keypad_evt_fifo (parameter depth, push/pop, full/empty); all other logic is in keypad_scan_ctrl.

Verification (SettleCycles = 2, DebounceScans = 3, FifoDepth = 4)
REQ-035 Reset with row_in = 4'hF -> col_out = 4'hF, key_state = 0, evt_valid = 0, overflow = 0.
REQ-036 Key 5 (col 1, row 1) held for 3 ticks -> key_state[5] = 1 after the 3rd scan; evt_code = 5'b1_0101 with evt_valid = 1.
REQ-037 Key 5 pressed for 2 scans, open 1 scan, pressed 2 scans -> no event, key_state[5] = 0.
REQ-038 evt_ready = 0 and keys 0..4 pressed for 3 scans -> 4 events queued (keys 0..3), one overflow pulse, key_state = 16'h001F.
REQ-039 Key 5 pressed, then released for 3 scans -> release event 5'b0_0101 with the macro defined; with it undefined, no event and key_state[5] = 0.
REQ-040 Reset asserted during UPDATE of col 2 with events queued -> IDLE next cycle, queue empty, key_state = 0.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_scan_pkg;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_UPDATE
  } scan_state_t;

  typedef struct packed {
    logic       press;
    logic [3:0] idx;
  } evt_code_t;

  // Active-low column drive pattern with only column c pulled low.
  function automatic logic [COLS-1:0] col_drive(input logic [1:0] c);
    return ~(COLS'(1) << c);
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Small event queue for key press/release codes; accepts push and pop together when full.
module keypad_evt_fifo
  import keypad_scan_pkg::*;
#(
  parameter int unsigned depth = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  evt_code_t push_data,
  input  logic      pop,
  output evt_code_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned CW = AW + 1;

  evt_code_t     mem [depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next_c;
  logic          do_pop_c;
  logic          do_push_c;

  // Accept decisions and next occupancy.
  always_comb begin
    do_pop_c     = pop && !empty;
    do_push_c    = push && (!full || do_pop_c);
    count_next_c = count;
    if (do_push_c && !do_pop_c) begin
      count_next_c = count + CW'(1);
    end else if (!do_push_c && do_pop_c) begin
      count_next_c = count - CW'(1);
    end
  end

  // Storage, pointers and registered full/empty flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      for (int unsigned i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push_c) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next_c;
      empty <= (count_next_c == '0);
      full  <= (count_next_c == CW'(depth));
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad matrix scanner with per-key debounce and an event queue.
// Optional macro KEYPAD_SCAN_CTRL_RELEASE_EVT_EN: queue release events as well as presses.
module keypad_scan_ctrl
  import keypad_scan_pkg::*;
#(
  parameter int unsigned SettleCycles  = 4,
  parameter int unsigned DebounceScans = 3,
  parameter int unsigned FifoDepth     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [ROWS-1:0]      row_in,
  output logic [COLS-1:0]      col_out,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [4:0]           evt_code,
  output logic                 overflow
);

  localparam int unsigned KEYS = ROWS * COLS;
  localparam int unsigned DW   = 3;
  localparam int unsigned SW   = 4;

  scan_state_t   state;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic [SW-1:0] settle_cnt;
  logic [3:0]    row_cap;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [DW-1:0] deb_cnt [KEYS];

  logic [3:0]    key_idx_c;
  logic          sample_c;
  logic          differ_c;
  logic [DW-1:0] cnt_inc_c;
  logic          toggle_c;
  logic          push_c;
  logic          pop_c;
  evt_code_t     push_data_c;
  evt_code_t     fifo_head;
  logic          fifo_full;
  logic          fifo_empty;

  // Two-flop synchronizer for the asynchronous row lines (idle high).
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= row_in;
      sync2 <= sync1;
    end
  end

  // Debounce decision for the key currently addressed in UPDATE.
  always_comb begin
    key_idx_c   = {col_idx, row_idx};
    sample_c    = row_cap[row_idx];
    differ_c    = (sample_c != key_state[key_idx_c]);
    cnt_inc_c   = deb_cnt[key_idx_c] + DW'(1);
    toggle_c    = (state == ST_UPDATE) && differ_c && (cnt_inc_c == DW'(DebounceScans));
`ifdef KEYPAD_SCAN_CTRL_RELEASE_EVT_EN
    push_c      = toggle_c;
`else
    push_c      = toggle_c && sample_c;
`endif
    push_data_c.press = sample_c;
    push_data_c.idx   = key_idx_c;
    pop_c       = evt_valid && evt_ready;
  end

  // Scan sequencer: settle each column, capture rows, then walk the four keys.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      col_idx    <= 2'd0;
      row_idx    <= 2'd0;
      settle_cnt <= '0;
      row_cap    <= 4'h0;
      col_out    <= 4'hF;
      key_state  <= '0;
      for (int unsigned k = 0; k < KEYS; k++) begin
        deb_cnt[k] <= '0;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          col_out <= 4'hF;
          if (tick) begin
            state      <= ST_SETTLE;
            col_idx    <= 2'd0;
            row_idx    <= 2'd0;
            settle_cnt <= '0;
            col_out    <= col_drive(2'd0);
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SW'(SettleCycles - 1)) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        ST_SAMPLE: begin
          row_cap <= ~sync2;
          row_idx <= 2'd0;
          state   <= ST_UPDATE;
        end
        ST_UPDATE: begin
          if (!differ_c) begin
            deb_cnt[key_idx_c] <= '0;
          end else if (toggle_c) begin
            deb_cnt[key_idx_c]   <= '0;
            key_state[key_idx_c] <= sample_c;
          end else begin
            deb_cnt[key_idx_c] <= cnt_inc_c;
          end
          row_idx <= row_idx + 2'd1;
          if (row_idx == 2'd3) begin
            if (col_idx == 2'd3) begin
              state   <= ST_IDLE;
              col_idx <= 2'd0;
              col_out <= 4'hF;
            end else begin
              state      <= ST_SETTLE;
              col_idx    <= col_idx + 2'd1;
              settle_cnt <= '0;
              col_out    <= col_drive(col_idx + 2'd1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Flag an event lost to a full queue that is not draining this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else begin
      overflow <= push_c && fifo_full && !pop_c;
    end
  end

  keypad_evt_fifo #(
    .depth(FifoDepth)
  ) u_evt_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_c),
    .push_data(push_data_c),
    .pop      (pop_c),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = fifo_head;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: matrix model, vector table, corner sequences, random scans vs. scan-level model.
module tb_keypad_scan_ctrl;

  localparam int Settle   = 2;
  localparam int DebScans = 3;
  localparam int FifoD    = 4;
  localparam int ScanLen  = 4 * (Settle + 1 + 4);
`ifdef KEYPAD_SCAN_CTRL_RELEASE_EVT_EN
  localparam bit RelEn = 1'b1;
`else
  localparam bit RelEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] key_state;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [4:0]  evt_code;
  logic        overflow;

  logic [15:0] pressed = 16'h0000;
  int          tests = 0;
  int          fails = 0;
  int          ovf_seen = 0;

  // Scan-level reference state.
  logic [15:0] m_vec;
  int          m_cnt [16];
  logic [4:0]  m_q [$];

  keypad_scan_ctrl #(
    .SettleCycles (Settle),
    .DebounceScans(DebScans),
    .FifoDepth    (FifoD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_state(key_state),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code (evt_code),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  // Switch matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pressed[c*4+r] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  always @(posedge clock) if (overflow) ovf_seen++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_vec = '0;
    for (int k = 0; k < 16; k++) m_cnt[k] = 0;
    m_q.delete();
  endtask

  // One full scan seen from the spec: every key sampled once, in index order.
  task automatic model_scan(input logic [15:0] p, output int ovf);
    ovf = 0;
    for (int k = 0; k < 16; k++) begin
      if (p[k] == m_vec[k]) begin
        m_cnt[k] = 0;
      end else begin
        m_cnt[k]++;
        if (m_cnt[k] == DebScans) begin
          m_vec[k] = p[k];
          m_cnt[k] = 0;
          if (p[k] || RelEn) begin
            if (m_q.size() < FifoD) m_q.push_back({p[k], 4'(k)});
            else ovf++;
          end
        end
      end
    end
  endtask

  task automatic hw_reset();
    reset = 1'b1;
    tick = 1'b0;
    evt_ready = 1'b0;
    pressed = 16'h0000;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    ovf_seen = 0;
    model_reset();
  endtask

  // One scan; ready_at = edge index whose cycle has evt_ready high (-1: none).
  task automatic run_scan(input logic [15:0] p, input int ready_at, input bit noise);
    int len;
    bit bad;
    pressed = p;
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    len = 0;
    bad = 1'b0;
    while (col_out != 4'hF && len < 200) begin
      if ($countones(~col_out) != 1) bad = 1'b1;
      evt_ready = (len == ready_at - 1);
      tick = noise && ($urandom_range(0, 7) == 0);
      len++;
      @(negedge clock);
    end
    tick = 1'b0;
    evt_ready = 1'b0;
    @(negedge clock);
    check("scan_len", len, ScanLen);
    check("col_one_low", bad, 0);
  endtask

  task automatic drain_all(output int n);
    n = 0;
    evt_ready = 1'b1;
    while (evt_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    evt_ready = 1'b0;
  endtask

  task automatic expect_pop(input logic [4:0] code);
    check("pop_valid", evt_valid, 1);
    check("pop_code", evt_code, code);
    evt_ready = 1'b1;
    @(negedge clock);
    evt_ready = 1'b0;
  endtask

  // Random-ready drain compared against the model queue.
  task automatic drain_rand(input int n);
    for (int i = 0; i < n; i++) begin
      evt_ready = 1'($urandom_range(0, 1));
      check("rnd_valid", evt_valid, m_q.size() != 0);
      if (evt_ready && evt_valid && m_q.size() != 0) check("rnd_pop", evt_code, m_q.pop_front());
      @(negedge clock);
    end
    evt_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] pressed;
    int          scans;
    logic [15:0] exp_state;
    logic [4:0]  exp_head;
    int          exp_events;
    int          exp_ovf;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int n;
    int eovf;
    logic [15:0] cur;

    vecs[0] = '{16'h0020, 3, 16'h0020, 5'h15, 1, 0};
    vecs[1] = '{16'h0020, 2, 16'h0000, 5'h00, 0, 0};
    vecs[2] = '{16'h001F, 3, 16'h001F, 5'h10, 4, 1};
    vecs[3] = '{16'h8001, 3, 16'h8001, 5'h10, 2, 0};
    vecs[4] = '{16'hFFFF, 2, 16'h0000, 5'h00, 0, 0};
    vecs[5] = '{16'h0020, 4, 16'h0020, 5'h15, 1, 0};
    vecs[6] = '{16'h8000, 3, 16'h8000, 5'h1F, 1, 0};

    // Reset state.
    hw_reset();
    check("rst_col_out", col_out, 4'hF);
    check("rst_key_state", key_state, 16'h0000);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_evt_code", evt_code, 5'h00);

    // Vector table: hold a pattern for N scans, then inspect state and queue.
    for (int i = 0; i < 7; i++) begin
      hw_reset();
      for (int s = 0; s < vecs[i].scans; s++) run_scan(vecs[i].pressed, -1, 1'b0);
      check($sformatf("v%0d_state", i), key_state, vecs[i].exp_state);
      check($sformatf("v%0d_head", i), evt_code, vecs[i].exp_head);
      check($sformatf("v%0d_ovf", i), ovf_seen, vecs[i].exp_ovf);
      drain_all(n);
      check($sformatf("v%0d_events", i), n, vecs[i].exp_events);
    end

    // Interrupted press never debounces.
    hw_reset();
    run_scan(16'h0020, -1, 1'b0);
    run_scan(16'h0020, -1, 1'b0);
    run_scan(16'h0000, -1, 1'b0);
    run_scan(16'h0020, -1, 1'b0);
    run_scan(16'h0020, -1, 1'b0);
    check("bounce_state", key_state, 16'h0000);
    check("bounce_valid", evt_valid, 0);

    // Five presses into a four-deep queue: FIFO order, one drop.
    hw_reset();
    repeat (3) run_scan(16'h001F, -1, 1'b0);
    check("full_ovf", ovf_seen, 1);
    check("full_state", key_state, 16'h001F);
    for (int k = 0; k < 4; k++) expect_pop({1'b1, 4'(k)});
    check("full_drained", evt_valid, 0);

    // Push and pop in the same cycle on a full queue.
    hw_reset();
    repeat (3) run_scan(16'h000F, -1, 1'b0);
    run_scan(16'h002F, -1, 1'b0);
    run_scan(16'h002F, -1, 1'b0);
    run_scan(16'h002F, 1 * 7 + 4 + 1, 1'b0);
    check("pp_ovf", ovf_seen, 0);
    check("pp_state", key_state, 16'h002F);
    expect_pop(5'h11);
    expect_pop(5'h12);
    expect_pop(5'h13);
    expect_pop(5'h15);
    check("pp_drained", evt_valid, 0);

    // Release of key 5.
    hw_reset();
    repeat (3) run_scan(16'h0020, -1, 1'b0);
    drain_all(n);
    check("rel_press_cnt", n, 1);
    repeat (3) run_scan(16'h0000, -1, 1'b0);
    check("rel_state", key_state, 16'h0000);
    check("rel_ovf", ovf_seen, 0);
    if (RelEn) begin
      check("rel_valid", evt_valid, 1);
      check("rel_code", evt_code, 5'h05);
    end else begin
      check("rel_valid", evt_valid, 0);
    end

    // Reset during UPDATE of column 2, at the very cycle key 8 would toggle.
    hw_reset();
    run_scan(16'h0001, -1, 1'b0);
    run_scan(16'h0101, -1, 1'b0);
    run_scan(16'h0101, -1, 1'b0);
    check("mid_queued", evt_valid, 1);
    pressed = 16'h0101;
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    repeat (2 * 7 + 3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_col_out", col_out, 4'hF);
    check("mid_state", key_state, 16'h0000);
    check("mid_valid", evt_valid, 0);
    check("mid_code", evt_code, 5'h00);
    check("mid_overflow", overflow, 0);
    @(negedge clock);
    check("mid_valid_after", evt_valid, 0);
    check("mid_col_idle", col_out, 4'hF);
    ovf_seen = 0;
    run_scan(16'h0000, -1, 1'b0);
    check("mid_rescan_valid", evt_valid, 0);

    // Randomized scans with stray ticks against the scan-level model.
    hw_reset();
    cur = 16'h0000;
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 3) == 0) cur = 16'($urandom) & 16'($urandom) & 16'($urandom);
      else if ($urandom_range(0, 1) == 1) cur = cur ^ (16'h0001 << $urandom_range(0, 15));
      ovf_seen = 0;
      run_scan(cur, -1, 1'b1);
      model_scan(cur, eovf);
      check("rnd_state", key_state, m_vec);
      check("rnd_ovf", ovf_seen, eovf);
      check("rnd_valid_end", evt_valid, m_q.size() != 0);
      if (m_q.size() != 0) check("rnd_head", evt_code, m_q[0]);
      drain_rand($urandom_range(0, 6));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
